// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encoding and
// default parameter values.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StMemWait = 2'd1,
    StErr     = 2'd2
  } state_e;

  localparam int unsigned MemTimeoutDef = 64;
  localparam int unsigned CntWDef       = 16;
  localparam int unsigned RegIdxW       = 5;

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter: counts enabled cycles and sticks at all-ones.
module sat_counter #(
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  output logic [Width-1:0] cnt_o
);

  logic [Width-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch flushes and data-memory
// wait handling with a timeout that parks the pipeline in a sticky error state.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = MemTimeoutDef,
  parameter int unsigned CNT_W       = CntWDef
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               IDEX_MemRead_i,
  input  logic [RegIdxW-1:0] IDEX_Rd_i,
  input  logic [RegIdxW-1:0] IFID_Rs1_i,
  input  logic [RegIdxW-1:0] IFID_Rs2_i,
  input  logic               Branch_taken_i,
  input  logic               mem_req_i,
  input  logic               mem_ready_i,
  output logic               PC_write_o,
  output logic               IF_stall_o,
  output logic               IF_flush_o,
  output logic               IDEX_flush_o,
  output logic               stall_all_o,
  output logic [1:0]         state_o,
  output logic               err_o,
  output logic [CNT_W-1:0]   stall_cnt_o,
  output logic [CNT_W-1:0]   flush_cnt_o
);

  localparam int unsigned WaitW = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);

  state_e           state_d, state_q;
  logic [WaitW-1:0] wait_d, wait_q;
  logic             err_d, err_q;
  logic             load_use, mem_wait;

  assign load_use = IDEX_MemRead_i && (IDEX_Rd_i != '0) &&
                    ((IDEX_Rd_i == IFID_Rs1_i) || (IDEX_Rd_i == IFID_Rs2_i));
  assign mem_wait = mem_req_i && !mem_ready_i;

  always_comb begin
    state_d      = state_q;
    wait_d       = wait_q;
    err_d        = err_q;
    PC_write_o   = 1'b1;
    IF_stall_o   = 1'b0;
    IF_flush_o   = 1'b0;
    IDEX_flush_o = 1'b0;
    stall_all_o  = 1'b0;

    unique case (state_q)
      StRun: begin
        if (mem_wait) begin
          PC_write_o  = 1'b0;
          IF_stall_o  = 1'b1;
          stall_all_o = 1'b1;
          state_d     = StMemWait;
          wait_d      = '0;
        end else if (load_use) begin
          PC_write_o   = 1'b0;
          IF_stall_o   = 1'b1;
          IDEX_flush_o = 1'b1;
        end else if (Branch_taken_i) begin
          IF_flush_o = 1'b1;
        end
      end
      StMemWait: begin
        // The completing cycle is still frozen; RUN resumes on the next edge.
        PC_write_o  = 1'b0;
        IF_stall_o  = 1'b1;
        stall_all_o = 1'b1;
        if (mem_ready_i) begin
          state_d = StRun;
        end else if (32'(wait_q) + 32'd1 >= MEM_TIMEOUT) begin
          state_d = StErr;
          err_d   = 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      StErr: begin
        PC_write_o  = 1'b0;
        IF_stall_o  = 1'b1;
        stall_all_o = 1'b1;
      end
      default: begin
        state_d = StRun;
      end
    endcase

    // Reset drives a bubble into both front-end registers and holds the PC.
    if (!rst_n) begin
      PC_write_o   = 1'b0;
      IF_stall_o   = 1'b0;
      IF_flush_o   = 1'b1;
      IDEX_flush_o = 1'b1;
      stall_all_o  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StRun;
      wait_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
    end
  end

  assign state_o = state_q;
  assign err_o   = err_q;

  sat_counter #(
    .Width (CNT_W)
  ) u_stall_cnt (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .en_i   (IF_stall_o),
    .cnt_o  (stall_cnt_o)
  );

  sat_counter #(
    .Width (CNT_W)
  ) u_flush_cnt (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .en_i   (IF_flush_o),
    .cnt_o  (flush_cnt_o)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed vector table, multi-cycle
// corner sequences and randomized traffic against a behavioural model.
module tb_hazard_ctrl;

  localparam int unsigned TO   = 4;
  localparam int unsigned CW   = 4;
  localparam int          CMAX = 15;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       mr, br, req, rdy;
  logic [4:0] rd, rs1, rs2;
  logic       pc_w, if_st, if_fl, idex_fl, st_all, err;
  logic [1:0] state;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int total = 0;
  int bad   = 0;

  // Reference model state: mode 0=run 1=waiting on memory 2=error.
  int m_mode, m_waited, m_err, m_stall, m_flush;

  always #5 clk = ~clk;

  hazard_ctrl #(
    .MEM_TIMEOUT (TO),
    .CNT_W       (CW)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .IDEX_MemRead_i (mr),
    .IDEX_Rd_i      (rd),
    .IFID_Rs1_i     (rs1),
    .IFID_Rs2_i     (rs2),
    .Branch_taken_i (br),
    .mem_req_i      (req),
    .mem_ready_i    (rdy),
    .PC_write_o     (pc_w),
    .IF_stall_o     (if_st),
    .IF_flush_o     (if_fl),
    .IDEX_flush_o   (idex_fl),
    .stall_all_o    (st_all),
    .state_o        (state),
    .err_o          (err),
    .stall_cnt_o    (stall_cnt),
    .flush_cnt_o    (flush_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    total++;
    if (act !== 32'(exp)) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_waited = 0; m_err = 0; m_stall = 0; m_flush = 0;
  endtask

  // Asserts reset mid-cycle, checks reset values, releases away from the edge.
  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    model_reset();
    chk("rst_pc", 32'(pc_w), 0);
    chk("rst_ifstall", 32'(if_st), 0);
    chk("rst_ifflush", 32'(if_fl), 1);
    chk("rst_idexflush", 32'(idex_fl), 1);
    chk("rst_stallall", 32'(st_all), 0);
    chk("rst_state", 32'(state), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_stallcnt", 32'(stall_cnt), 0);
    chk("rst_flushcnt", 32'(flush_cnt), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // One clock: drive inputs, check everything against the model mid-cycle,
  // then advance the model across the rising edge.
  task automatic step(input logic i_mr, input logic [4:0] i_rd, input logic [4:0] i_rs1,
                      input logic [4:0] i_rs2, input logic i_br, input logic i_req,
                      input logic i_rdy, output logic [4:0] seen);
    logic lu, mw;
    int e_pc, e_st, e_fl, e_idf, e_sa;
    mr = i_mr; rd = i_rd; rs1 = i_rs1; rs2 = i_rs2; br = i_br; req = i_req; rdy = i_rdy;
    #4;
    lu = i_mr && (i_rd != 0) && (i_rd == i_rs1 || i_rd == i_rs2);
    mw = i_req && !i_rdy;
    if (m_mode != 0 || mw) begin
      e_pc = 0; e_st = 1; e_fl = 0; e_idf = 0; e_sa = 1;
    end else if (lu) begin
      e_pc = 0; e_st = 1; e_fl = 0; e_idf = 1; e_sa = 0;
    end else if (i_br) begin
      e_pc = 1; e_st = 0; e_fl = 1; e_idf = 0; e_sa = 0;
    end else begin
      e_pc = 1; e_st = 0; e_fl = 0; e_idf = 0; e_sa = 0;
    end
    seen = {pc_w, if_st, if_fl, idex_fl, st_all};
    chk("pc_write", 32'(pc_w), e_pc);
    chk("if_stall", 32'(if_st), e_st);
    chk("if_flush", 32'(if_fl), e_fl);
    chk("idex_flush", 32'(idex_fl), e_idf);
    chk("stall_all", 32'(st_all), e_sa);
    chk("state", 32'(state), m_mode);
    chk("err", 32'(err), m_err);
    chk("stall_cnt", 32'(stall_cnt), m_stall);
    chk("flush_cnt", 32'(flush_cnt), m_flush);
    if (e_st == 1) m_stall = (m_stall + 1 > CMAX) ? CMAX : m_stall + 1;
    if (e_fl == 1) m_flush = (m_flush + 1 > CMAX) ? CMAX : m_flush + 1;
    if (m_mode == 0 && mw) begin
      m_mode = 1; m_waited = 0;
    end else if (m_mode == 1) begin
      if (i_rdy) begin
        m_mode = 0;
      end else begin
        m_waited++;
        if (m_waited >= TO) begin
          m_mode = 2; m_err = 1;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic mr; logic [4:0] rd; logic [4:0] rs1; logic [4:0] rs2;
    logic br; logic req; logic rdy;
    logic [4:0] exp;  // {pc_write, if_stall, if_flush, idex_flush, stall_all}
    string name;
  } vec_t;

  vec_t tbl[10];

  initial begin
    logic [4:0] seen;
    int sa_cycles;
    tbl[0] = '{1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 5'b10000, "normal"};
    tbl[1] = '{1'b1, 5'd5, 5'd5, 5'd2, 1'b0, 1'b0, 1'b0, 5'b01010, "lu_rs1"};
    tbl[2] = '{1'b1, 5'd9, 5'd3, 5'd9, 1'b0, 1'b0, 1'b0, 5'b01010, "lu_rs2"};
    tbl[3] = '{1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'b10000, "load_x0"};
    tbl[4] = '{1'b0, 5'd5, 5'd5, 5'd5, 1'b0, 1'b0, 1'b0, 5'b10000, "no_load"};
    tbl[5] = '{1'b1, 5'd7, 5'd3, 5'd4, 1'b0, 1'b0, 1'b0, 5'b10000, "load_nomatch"};
    tbl[6] = '{1'b0, 5'd0, 5'd1, 5'd1, 1'b1, 1'b0, 1'b0, 5'b10100, "branch"};
    tbl[7] = '{1'b1, 5'd6, 5'd6, 5'd1, 1'b1, 1'b0, 1'b0, 5'b01010, "lu_and_branch"};
    tbl[8] = '{1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b1, 1'b1, 5'b10000, "req_ready"};
    tbl[9] = '{1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0, 1'b1, 5'b10000, "ready_only"};

    mr = 0; rd = 0; rs1 = 0; rs2 = 0; br = 0; req = 0; rdy = 0;
    rst_n = 1'b0;
    #12;
    do_reset();

    for (int i = 0; i < 10; i++) begin
      step(tbl[i].mr, tbl[i].rd, tbl[i].rs1, tbl[i].rs2, tbl[i].br, tbl[i].req,
           tbl[i].rdy, seen);
      chk({"vec_", tbl[i].name}, 32'(seen), int'(tbl[i].exp));
    end

    // Single load-use stall bumps the stall counter by exactly one.
    do_reset();
    step(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, seen);
    chk("lu_stallcnt", 32'(stall_cnt), 1);

    // Load-use masks a branch; the flush lands next cycle if still taken.
    step(1'b1, 5'd6, 5'd6, 5'd0, 1'b1, 1'b0, 1'b0, seen);
    chk("lu_br_masked", 32'(seen), 5'b01010);
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, seen);
    chk("br_after_lu", 32'(seen), 5'b10100);

    // Memory stall: ready low for 3 cycles then high gives 4 frozen cycles.
    sa_cycles = 0;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, (i == 3), seen);
      if (seen[0]) sa_cycles++;
    end
    chk("memwait_cycles", 32'(sa_cycles), 4);
    chk("memwait_back_run", 32'(state), 0);
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, seen);

    // Timeout: 4 waiting cycles lead to the error state, which ignores ready.
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, seen);
    for (int i = 0; i < TO; i++) step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, seen);
    chk("timeout_state", 32'(state), 2);
    chk("timeout_err", 32'(err), 1);
    for (int i = 0; i < 3; i++) step(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, seen);
    chk("err_sticky", 32'(err), 1);
    do_reset();
    chk("post_err_state", 32'(state), 0);

    // 2^CW + 3 taken branches saturate the flush counter.
    for (int i = 0; i < (1 << CW) + 3; i++) step(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, seen);
    chk("flush_sat", 32'(flush_cnt), CMAX);

    // Randomized traffic with occasional resets, including inside wait/error.
    do_reset();
    for (int n = 0; n < 500; n++) begin
      if ((m_mode == 2 && $urandom_range(0, 3) == 0) || $urandom_range(0, 59) == 0) begin
        do_reset();
      end else begin
        step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), seen);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
